// File: rtl/rwstack_p.sv
// rwstack_p: LIFO stack with a registered top entry and deeper entries in a simple dual-port RAM.
// Optional sticky overflow/underflow reporting is enabled by defining RWSTACK_P_ERR_EN.
module rwstack_p #(
   parameter int WIDTH       = 8,
   parameter int DEPTHBITS   = 8,
   parameter int AFULL_LEVEL = 2**DEPTHBITS - 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_sreset,
   input  logic                 i_enable,
   input  logic [WIDTH-1:0]     i_din,
   input  logic                 i_push,
   input  logic                 i_pop,
   output logic [WIDTH-1:0]     o_top,
   output logic                 o_empty,
   output logic                 o_full,
   output logic                 o_afull,
   output logic [DEPTHBITS:0]   o_count,
   output logic [1:0]           o_err
);

   localparam int CAP = 2**DEPTHBITS;

   typedef logic [DEPTHBITS:0]   cnt_t;
   typedef logic [DEPTHBITS-1:0] addr_t;

   localparam cnt_t CAP_W = cnt_t'(CAP);

   logic [WIDTH-1:0] r_top;
   logic [WIDTH-1:0] r_below;
   logic [WIDTH-1:0] w_top_nx;
   cnt_t             r_count;
   cnt_t             w_count_nx;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_repl;
   logic             w_we;
   addr_t            w_waddr;
   addr_t            w_raddr;

   // Entry k (0 = bottom) lives at RAM address k; the top entry is held in r_top instead.
   logic [WIDTH-1:0] r_mem [0:CAP-2];

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CAP_W);

   // Push+pop on an empty stack degenerates to a plain push.
   assign w_push = i_enable & i_push & (~i_pop | w_empty) & ~w_full;
   assign w_pop  = i_enable & i_pop & ~i_push & ~w_empty;
   assign w_repl = i_enable & i_push & i_pop & ~w_empty;

   always_comb begin
      w_count_nx = r_count;
      w_top_nx   = r_top;
      if (i_sreset) begin
         w_count_nx = '0;
         w_top_nx   = '0;
      end else if (w_push) begin
         w_count_nx = r_count + cnt_t'(1);
         w_top_nx   = i_din;
      end else if (w_pop) begin
         w_count_nx = r_count - cnt_t'(1);
         w_top_nx   = (r_count == cnt_t'(1)) ? '0 : r_below;
      end else if (w_repl) begin
         w_top_nx   = i_din;
      end
   end

   // Old top spills to the slot just under the new top; nothing to spill when empty.
   assign w_we    = w_push & ~w_empty & ~i_sreset;
   assign w_waddr = r_count[DEPTHBITS-1:0] - addr_t'(1);
   // r_below always tracks the entry just under the next top, so a pop has no read latency.
   assign w_raddr = w_count_nx[DEPTHBITS-1:0] - addr_t'(2);

   always_ff @(posedge i_clk) begin
      if (w_we) r_mem[w_waddr] <= r_top;
   end

   always_ff @(posedge i_clk) begin
      if (w_we && (w_waddr == w_raddr)) r_below <= r_top;
      else                              r_below <= r_mem[w_raddr];
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
         r_top   <= '0;
      end else begin
         r_count <= w_count_nx;
         r_top   <= w_top_nx;
      end
   end

   assign o_top   = r_top;
   assign o_count = r_count;
   assign o_empty = w_empty;
   assign o_full  = w_full;

   generate
      if (AFULL_LEVEL <= 0) begin : g_afull_const
         assign o_afull = 1'b1;
      end else begin : g_afull_cmp
         assign o_afull = (r_count >= cnt_t'(AFULL_LEVEL));
      end
   endgenerate

`ifdef RWSTACK_P_ERR_EN
   logic [1:0] r_err;
   logic       w_drop;
   logic       w_under;

   assign w_drop  = i_enable & i_push & ~i_pop & w_full;
   assign w_under = i_enable & i_pop & ~i_push & w_empty;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)       r_err <= 2'b00;
      else if (i_sreset) r_err <= 2'b00;
      else               r_err <= r_err | {w_under, w_drop};
   end

   assign o_err = r_err;
`else
   assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_rwstack_p.sv
// Testbench for rwstack_p: two instances (4-deep and 16-deep) driven in lockstep
// and compared against an array-based LIFO model after every edge.
module tb_rwstack_p;

`ifdef RWSTACK_P_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_sreset = 1'b0;
   logic       i_enable = 1'b0;
   logic [7:0] i_din = '0;
   logic       i_push = 1'b0;
   logic       i_pop = 1'b0;

   logic [7:0] a_top, b_top;
   logic       a_empty, a_full, a_afull, b_empty, b_full, b_afull;
   logic [2:0] a_count;
   logic [4:0] b_count;
   logic [1:0] a_err, b_err;

   int checks = 0;
   int failures = 0;

   int         cap [2] = '{4, 16};
   int         afl [2] = '{3, 12};
   int         cnt [2];
   logic [7:0] stk [2][16];
   logic [1:0] err [2];

   always #5 i_clk = ~i_clk;

   rwstack_p #(.WIDTH(8), .DEPTHBITS(2), .AFULL_LEVEL(3)) dut_a (
      .i_clk(i_clk), .i_reset(i_reset), .i_sreset(i_sreset), .i_enable(i_enable),
      .i_din(i_din), .i_push(i_push), .i_pop(i_pop),
      .o_top(a_top), .o_empty(a_empty), .o_full(a_full), .o_afull(a_afull),
      .o_count(a_count), .o_err(a_err));

   rwstack_p #(.WIDTH(8), .DEPTHBITS(4), .AFULL_LEVEL(12)) dut_b (
      .i_clk(i_clk), .i_reset(i_reset), .i_sreset(i_sreset), .i_enable(i_enable),
      .i_din(i_din), .i_push(i_push), .i_pop(i_pop),
      .o_top(b_top), .o_empty(b_empty), .o_full(b_full), .o_afull(b_afull),
      .o_count(b_count), .o_err(b_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_top(input int k);
      return (cnt[k] > 0) ? stk[k][cnt[k]-1] : 8'h00;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, " a.top"},   {24'h0, a_top},   {24'h0, exp_top(0)});
      chk({tag, " a.count"}, {29'h0, a_count}, cnt[0]);
      chk({tag, " a.empty"}, {31'h0, a_empty}, {31'h0, cnt[0] == 0});
      chk({tag, " a.full"},  {31'h0, a_full},  {31'h0, cnt[0] == cap[0]});
      chk({tag, " a.afull"}, {31'h0, a_afull}, {31'h0, cnt[0] >= afl[0]});
      chk({tag, " a.err"},   {30'h0, a_err},   {30'h0, err[0]});
      chk({tag, " b.top"},   {24'h0, b_top},   {24'h0, exp_top(1)});
      chk({tag, " b.count"}, {27'h0, b_count}, cnt[1]);
      chk({tag, " b.empty"}, {31'h0, b_empty}, {31'h0, cnt[1] == 0});
      chk({tag, " b.full"},  {31'h0, b_full},  {31'h0, cnt[1] == cap[1]});
      chk({tag, " b.afull"}, {31'h0, b_afull}, {31'h0, cnt[1] >= afl[1]});
      chk({tag, " b.err"},   {30'h0, b_err},   {30'h0, err[1]});
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         cnt[k] = 0;
         err[k] = 2'b00;
      end
   endtask

   task automatic model_op(input logic p, input logic q, input logic [7:0] d, input logic e, input logic s);
      for (int k = 0; k < 2; k++) begin
         if (s) begin
            cnt[k] = 0;
            err[k] = 2'b00;
         end else if (e) begin
            if (p && (!q || cnt[k] == 0)) begin
               if (cnt[k] < cap[k]) begin
                  stk[k][cnt[k]] = d;
                  cnt[k]++;
               end else if (ERR_EN) err[k][0] = 1'b1;
            end else if (q && !p) begin
               if (cnt[k] > 0) cnt[k]--;
               else if (ERR_EN) err[k][1] = 1'b1;
            end else if (p && q) begin
               stk[k][cnt[k]-1] = d;
            end
         end
      end
   endtask

   task automatic step(input string tag, input logic p, input logic q, input logic [7:0] d,
                       input logic e = 1'b1, input logic s = 1'b0);
      i_push = p; i_pop = q; i_din = d; i_enable = e; i_sreset = s;
      model_op(p, q, d, e, s);
      @(posedge i_clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic p, q, e, s;
      model_reset();
      #12;
      check_all("reset");
      @(negedge i_clk);
      i_reset = 1'b0;
      @(posedge i_clk);
      #1;

      step("push11", 1, 0, 8'h11);
      step("push22", 1, 0, 8'h22);
      step("push33", 1, 0, 8'h33);
      step("push44", 1, 0, 8'h44);
      for (int i = 0; i < 4; i++) step("pop4", 0, 1, 8'h00);

      step("pushA1", 1, 0, 8'hA1);
      step("b2b_pop", 0, 1, 8'h00);
      step("b2b_pushB2", 1, 0, 8'hB2);
      step("b2b_pop2", 0, 1, 8'h00);

      step("r_push", 1, 0, 8'h11);
      step("r_push", 1, 0, 8'h22);
      step("r_push", 1, 0, 8'h33);
      step("replace", 1, 1, 8'h5A);
      step("pop_after_repl", 0, 1, 8'h00);

      step("sreset", 1, 1, 8'h00, 1, 1);
      for (int i = 0; i < 4; i++) step("fill", 1, 0, 8'h60 + 8'(i));
      step("push_full", 1, 0, 8'h99);
      step("repl_full", 1, 1, 8'h77);
      for (int i = 0; i < 4; i++) step("drain", 0, 1, 8'h00);
      step("pop_empty", 0, 1, 8'h00);
      step("pushpop_empty", 1, 1, 8'h3C);
      step("sreset_en_low", 1, 0, 8'h00, 0, 1);

      for (int i = 0; i < 12; i++) step("afull_fill", 1, 0, 8'hC0 + 8'(i));
      step("afull_pop", 0, 1, 8'h00);
      step("afull_push", 1, 0, 8'hEE);
      for (int i = 0; i < 6; i++) step("disabled", 1'(i), 1'(i >> 1), 8'hF0, 0);

      @(negedge i_clk);
      i_push = 1'b1; i_pop = 1'b0; i_enable = 1'b1;
      #2;
      i_reset = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      @(posedge i_clk);
      #1;
      check_all("async_hold");
      i_reset = 1'b0;
      step("post_reset", 1, 0, 8'h42);
      step("post_reset_pop", 0, 1, 8'h00);

      for (int i = 0; i < 600; i++) begin
         p = ($urandom_range(0, 99) < ((i < 300) ? 65 : 35));
         q = ($urandom_range(0, 99) < ((i < 300) ? 40 : 65));
         e = ($urandom_range(0, 9) != 0);
         s = ($urandom_range(0, 79) == 0);
         step("random", p, q, 8'($urandom), e, s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rwstack_p.md
# rwstack_p

Parametrised LIFO stack, the successor to the original read/write stack. It holds the top of stack in a register, so o_top is always valid with no read latency, and keeps the deeper entries in an inferred simple dual-port RAM. It adds three things the original lacks:
- simultaneous push+pop, which replaces the top entry;
- an occupancy count and a programmable almost-full flag;
- optional sticky overflow/underflow error reporting.

It serves parser and expression-evaluation datapaths that need one stack operation per cycle.

## Interface
- WIDTH, 8, data width in bits.
- DEPTHBITS, 8, log2 of capacity; capacity is CAP = 2**DEPTHBITS entries, top register included.
- AFULL_LEVEL, 2**DEPTHBITS-4, o_afull asserts when o_count >= AFULL_LEVEL.

- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_sreset  in  1  synchronous reset; same effect as i_reset at the next edge; overrides i_enable.
- i_enable  in  1  operations take effect only when high.
- i_din  in  WIDTH  push data.
- i_push  in  1  push request.
- i_pop  in  1  pop request.
- o_top  out  WIDTH  current top entry; 0 when empty.
- o_empty  out  1  o_count == 0.
- o_full  out  1  o_count == CAP.
- o_afull  out  1  o_count >= AFULL_LEVEL.
- o_count  out  DEPTHBITS+1  number of entries held.
- o_err  out  2  sticky; bit0 = overflow, bit1 = underflow.

## Operation
- Reset (i_reset or i_sreset) sets:
  - o_count = 0, o_top = 0, o_empty = 1, o_full = 0, o_afull = 0 (or 1 if AFULL_LEVEL == 0), o_err = 0.
  - RAM contents are don't-care.
- With i_enable high, the operation is decoded from {push, pop}:
  - push only, not full: o_top <= i_din; the old top goes to RAM; count +1.
  - push only, full: request dropped; state unchanged; overflow handling per Configuration.
  - pop only, count > 1: o_top <= the next entry down; count -1.
  - pop only, count == 1: o_top <= 0; count <= 0.
  - pop only, empty: ignored; underflow handling per Configuration.
  - push+pop, not empty: replace; o_top <= i_din; count unchanged; the RAM is not written. This is legal when full.
  - push+pop, empty: treated as push only; no underflow.
  - neither: hold.
- With i_enable low, all state holds; i_push and i_pop are ignored and raise no errors.
- LIFO order must hold for any sequence of operations at one per cycle, including push→pop, pop→pop and pop→push back-to-back.
  - The implementation drives the RAM read address from the next-state pointer.
  - It bypasses a same-cycle RAM write into the read path.
- Count and pointer arithmetic is unsigned, DEPTHBITS+1 bits wide, and never wraps. The guards above keep count in the range 0..CAP.

## Timing
- All outputs are registered or decoded from registers; there is no combinational path from inputs to outputs.
- o_top, o_count and all flags reflect an operation on the first edge after it is sampled.
- Throughput is one operation per cycle, sustained, with no stall output.
- An asynchronous i_reset mid-operation clears state immediately; the first operation is accepted on the first edge after deassertion.

## Configuration
- Macro RWSTACK_P_ERR_EN.
- When defined:
  - a dropped push on full sets o_err[0];
  - an ignored pop on empty sets o_err[1];
  - both bits are sticky until i_reset or i_sreset.
- When undefined:
  - o_err is tied to 2'b00 and the error logic is not built;
  - drop and ignore behaviour is identical to the defined case.

## Test plan
- WIDTH=8, DEPTHBITS=2: push 0x11, 0x22, 0x33, 0x44 -> o_count 4, o_full=1, o_top=0x44. Then pop ×4 on consecutive cycles -> o_top sequence 0x33, 0x22, 0x11, 0x00, with o_empty=1 at the end.
- Push 0xA1, then on the next cycle pop, push 0xB2, pop -> o_top 0xA1, 0x00, 0xB2, 0x00, with o_count 1, 0, 1, 0.
- With 3 entries (top 0x33), push+pop with i_din=0x5A -> o_top=0x5A, o_count 3. Then pop -> o_top=0x22.
- Full stack, push 0x99 with RWSTACK_P_ERR_EN defined -> o_top unchanged, o_count 4, o_err=2'b01. Then pop on empty after draining -> o_err=2'b11. i_sreset -> o_err=0, o_count 0. Without the macro -> o_err stays 0.
- DEPTHBITS=4, AFULL_LEVEL=12: push 12 entries -> o_afull rises on the edge taking o_count to 12. Pop once -> o_afull falls.
- i_enable=0 with push/pop toggling -> no state change. Assert i_reset asynchronously mid-burst -> all outputs at reset values before the next edge.
